vga_text_overlay: RTL and testbench

- Parametrised successor to the fixed-letter VGA picture generator. Draws a runtime-writable line of N_CHARS glyphs from an internal 8x8 font, scaled by SCALE, at a programmable window position.
- Supports static, blink and horizontal-scroll modes.
- Sits between vga_ctrl (pix_x/pix_y/pix_valid) and the RGB565 output path. Adds a fixed 2-cycle pipeline latency.

---
 rtl/vga_text_overlay.sv | 200 ++++++++++++++++++++
 tb/tb_vga_text_overlay.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_text_overlay.sv
// vga_text_overlay: overlays a runtime-writable line of 8x8 glyphs, scaled by
// SCALE, onto the pixel stream from the VGA timing generator. Supports static,
// blink and horizontal-scroll modes. Fixed 2-cycle latency from pix_x/pix_y to
// pix_data.
module vga_text_overlay #(
  parameter int          N_CHARS      = 8,
  parameter int          SCALE        = 4,
  parameter logic [9:0]  TEXT_X0      = 10'd192,
  parameter logic [9:0]  TEXT_Y0      = 10'd224,
  parameter logic [15:0] FG_COLOR     = 16'hFFFF,
  parameter logic [15:0] BG_COLOR     = 16'h0000,
  parameter int          BLINK_FRAMES = 30,
  parameter int          SCROLL_STEP  = 1,
  localparam int         AW           = $clog2(N_CHARS)
) (
  input  logic          vga_clk,
  input  logic          sys_rst,
  input  logic [9:0]    pix_x,
  input  logic [9:0]    pix_y,
  input  logic          pix_valid,
  input  logic [1:0]    mode,
  input  logic          char_we,
  input  logic [AW-1:0] char_addr,
  input  logic [6:0]    char_code,
  output logic          frame_tick,
  output logic [15:0]   pix_data
);

  localparam int          TEXT_W = N_CHARS * 8 * SCALE;
  localparam int          TEXT_H = 8 * SCALE;
  localparam int          SH     = $clog2(SCALE);
  localparam int          BW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [10:0] W_L    = 11'(TEXT_W);
  localparam logic [10:0] X_END  = 11'(int'(TEXT_X0) + TEXT_W);
  localparam logic [10:0] Y_END  = 11'(int'(TEXT_Y0) + TEXT_H);

  // Font ROM: one 64-bit word per glyph, row 0 in the top byte, bit 7 = leftmost.
  function automatic logic [63:0] glyph(input logic [6:0] code);
    logic [63:0] g;
    g = 64'h0;
    case (code)
      7'h30: g = 64'h3C666E7666663C00;
      7'h31: g = 64'h1838181818187E00;
      7'h32: g = 64'h3C66060C30607E00;
      7'h33: g = 64'h3C66061C06663C00;
      7'h34: g = 64'h0C1C3C6C7E0C0C00;
      7'h35: g = 64'h7E607C0606663C00;
      7'h36: g = 64'h3C607C6666663C00;
      7'h37: g = 64'h7E060C1830303000;
      7'h38: g = 64'h3C66663C66663C00;
      7'h39: g = 64'h3C66663E060C3800;
      7'h41: g = 64'h183C66667E666600;
      7'h42: g = 64'h7C66667C66667C00;
      7'h43: g = 64'h3C66606060663C00;
      7'h44: g = 64'h786C6666666C7800;
      7'h45: g = 64'h7E60607C60607E00;
      7'h46: g = 64'h7E60607C60606000;
      7'h47: g = 64'h3C66606E66663C00;
      7'h48: g = 64'h6666667E66666600;
      7'h49: g = 64'h3C18181818183C00;
      7'h4A: g = 64'h1E0C0C0C0C6C3800;
      7'h4B: g = 64'h666C7870786C6600;
      7'h4C: g = 64'h6060606060607E00;
      7'h4D: g = 64'h63777F6B63636300;
      7'h4E: g = 64'h66767E7E6E666600;
      7'h4F: g = 64'h3C66666666663C00;
      7'h50: g = 64'h7C66667C60606000;
      7'h51: g = 64'h3C666666663C0E00;
      7'h52: g = 64'h7C66667C786C6600;
      7'h53: g = 64'h3C66603C06663C00;
      7'h54: g = 64'h7E18181818181800;
      7'h55: g = 64'h6666666666663C00;
      7'h56: g = 64'h66666666663C1800;
      7'h57: g = 64'h6363636B7F776300;
      7'h58: g = 64'h66663C183C666600;
      7'h59: g = 64'h6666663C18181800;
      7'h5A: g = 64'h7E060C1830607E00;
      7'h7F: g = 64'hFFFFFFFFFFFFFFFF;
      default: g = 64'h0;
    endcase
    return g;
  endfunction

  logic [6:0]    char_mem [N_CHARS];
  logic [9:0]    scroll_reg;
  logic [9:0]    scroll_next;
  logic [BW-1:0] blink_cnt_reg;
  logic          visible_reg;

  logic          tick;
  logic          addr_ok;
  logic          in_win;
  logic [9:0]    dx;
  logic [9:0]    dy;
  logic [10:0]   u_sum;
  logic [10:0]   u_mod;
  logic [10:0]   sc_sum;
  logic [AW-1:0] idx;

  logic          valid_s1_reg;
  logic          in_win_s1_reg;
  logic          vis_s1_reg;
  logic [2:0]    col_s1_reg;
  logic [2:0]    row_s1_reg;
  logic [6:0]    code_s1_reg;
  logic [63:0]   glyph_s1;
  logic [7:0]    row_bits;
  logic          lit;

  assign tick    = pix_valid && (pix_x == 10'd0) && (pix_y == 10'd0);
  assign addr_ok = ({1'b0, char_addr} < (AW+1)'(N_CHARS));

  // Window test and wrapped horizontal coordinate; operands are both below
  // TEXT_W inside the window, so one conditional subtract suffices.
  always_comb begin
    dx     = pix_x - TEXT_X0;
    dy     = pix_y - TEXT_Y0;
    in_win = pix_valid && (pix_x >= TEXT_X0) && ({1'b0, pix_x} < X_END)
             && (pix_y >= TEXT_Y0) && ({1'b0, pix_y} < Y_END);
    u_sum  = {1'b0, dx} + {1'b0, scroll_reg};
    u_mod  = (u_sum >= W_L) ? (u_sum - W_L) : u_sum;
    idx    = AW'(u_mod >> (3 + SH));
    sc_sum = {1'b0, scroll_reg} + 11'(SCROLL_STEP);
    scroll_next = 10'((sc_sum >= W_L) ? (sc_sum - W_L) : sc_sum);
  end

  // Character buffer: one register per entry, cleared to spaces on reset.
  for (genvar gi = 0; gi < N_CHARS; gi++) begin : g_buf
    // Entry gi captures char_code when addressed by an in-range write.
    always_ff @(posedge vga_clk) begin
      if (sys_rst)
        char_mem[gi] <= 7'h20;
      else if (char_we && addr_ok && (char_addr == AW'(gi)))
        char_mem[gi] <= char_code;
    end
  end

  // Scroll offset advances once per frame while scrolling; otherwise holds.
  always_ff @(posedge vga_clk) begin
    if (sys_rst)
      scroll_reg <= 10'd0;
    else if (tick && mode[1])
      scroll_reg <= scroll_next;
  end

  // Blink counter: toggles visibility every BLINK_FRAMES ticks, forced visible when off.
  always_ff @(posedge vga_clk) begin
    if (sys_rst || !mode[0]) begin
      blink_cnt_reg <= '0;
      visible_reg   <= 1'b1;
    end else if (tick) begin
      if (blink_cnt_reg == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_reg <= '0;
        visible_reg   <= ~visible_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + 1'b1;
      end
    end
  end

  // Stage 1: capture glyph coordinates, buffered code and the visibility in force for this pixel.
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      valid_s1_reg  <= 1'b0;
      in_win_s1_reg <= 1'b0;
      vis_s1_reg    <= 1'b1;
      col_s1_reg    <= 3'd0;
      row_s1_reg    <= 3'd0;
      code_s1_reg   <= 7'h20;
    end else begin
      valid_s1_reg  <= pix_valid;
      in_win_s1_reg <= in_win;
      vis_s1_reg    <= visible_reg;
      col_s1_reg    <= 3'(u_mod >> SH);
      row_s1_reg    <= 3'(dy >> SH);
      code_s1_reg   <= char_mem[idx];
    end
  end

  assign glyph_s1 = glyph(code_s1_reg);
  assign row_bits = glyph_s1[{~row_s1_reg, 3'b000} +: 8];
  assign lit      = row_bits[~col_s1_reg];

  // Stage 2: colour selection and registered frame tick.
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      pix_data   <= 16'h0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= tick;
      if (!valid_s1_reg)
        pix_data <= 16'h0;
      else if (in_win_s1_reg && vis_s1_reg && lit)
        pix_data <= FG_COLOR;
      else
        pix_data <= BG_COLOR;
    end
  end

endmodule

// File: tb/tb_vga_text_overlay.sv
// Testbench for vga_text_overlay: directed steps followed by randomized frames,
// every cycle compared against a pixel-level reference model.
module tb_vga_text_overlay;

  localparam int          NC  = 6;
  localparam int          SC  = 4;
  localparam int          X0  = 192;
  localparam int          Y0  = 224;
  localparam int          W   = NC * 8 * SC;
  localparam int          H   = 8 * SC;
  localparam int          BF  = 2;
  localparam int          STP = 1;
  localparam logic [15:0] FG  = 16'hFFFF;
  localparam logic [15:0] BG  = 16'h0000;

  logic        vga_clk = 1'b0;
  logic        sys_rst;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        pix_valid;
  logic [1:0]  mode;
  logic        char_we;
  logic [2:0]  char_addr;
  logic [6:0]  char_code;
  logic        frame_tick;
  logic [15:0] pix_data;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  int          m_buf [NC];
  int          m_scroll_ticks;
  int          m_blink_ticks;
  int          m_scroll;
  bit          m_vis;
  logic [15:0] e_s1;
  logic [15:0] exp_pix;
  logic        exp_tick;

  vga_text_overlay #(
    .N_CHARS(NC), .SCALE(SC), .TEXT_X0(10'd192), .TEXT_Y0(10'd224),
    .FG_COLOR(FG), .BG_COLOR(BG), .BLINK_FRAMES(BF), .SCROLL_STEP(STP)
  ) dut (
    .vga_clk(vga_clk), .sys_rst(sys_rst), .pix_x(pix_x), .pix_y(pix_y),
    .pix_valid(pix_valid), .mode(mode), .char_we(char_we),
    .char_addr(char_addr), .char_code(char_code),
    .frame_tick(frame_tick), .pix_data(pix_data)
  );

  always #5 vga_clk = ~vga_clk;

  // Only the codes the bench ever writes need a glyph here
  function automatic logic [7:0] font_row(int code, int row);
    logic [7:0] a [8];
    a = '{8'h18, 8'h3C, 8'h66, 8'h66, 8'h7E, 8'h66, 8'h66, 8'h00};
    if (code == 'h7F) return 8'hFF;
    if (code == 'h41) return a[row];
    return 8'h00;
  endfunction

  function automatic logic [15:0] expect_pix(bit v, int x, int y);
    int u, idx, col, row;
    logic [7:0] bits;
    if (!v) return 16'h0;
    if (x < X0 || x >= X0 + W || y < Y0 || y >= Y0 + H) return BG;
    u    = (x - X0 + m_scroll) % W;
    idx  = u / (8 * SC);
    col  = (u / SC) % 8;
    row  = ((y - Y0) / SC) % 8;
    bits = font_row(m_buf[idx], row);
    return (m_vis && bits[7 - col]) ? FG : BG;
  endfunction

  task automatic check(string tag, logic [15:0] got, logic [15:0] want);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) m_buf[i] = 'h20;
    m_scroll_ticks = 0;
    m_blink_ticks  = 0;
    m_scroll       = 0;
    m_vis          = 1'b1;
    e_s1           = 16'h0;
    exp_pix        = 16'h0;
    exp_tick       = 1'b0;
  endtask

  // One pixel clock: drive, clock, advance the model, compare both outputs.
  task automatic step(bit v, int x, int y);
    logic [15:0] e_new;
    bit t_new;
    pix_valid = v;
    pix_x     = 10'(x);
    pix_y     = 10'(y);
    e_new = expect_pix(v, x, y);
    t_new = v && x == 0 && y == 0;
    @(posedge vga_clk);
    #1;
    if (sys_rst) begin
      model_reset();
    end else begin
      exp_pix  = e_s1;
      e_s1     = e_new;
      exp_tick = t_new;
      if (char_we && int'(char_addr) < NC) m_buf[char_addr] = int'(char_code);
      if (t_new && mode[1]) m_scroll_ticks++;
      if (!mode[0]) m_blink_ticks = 0;
      else if (t_new) m_blink_ticks++;
      m_scroll = (m_scroll_ticks * STP) % W;
      m_vis    = ((m_blink_ticks / BF) % 2) == 0;
    end
    check($sformatf("pix(%0d,%0d,v%0d)", x, y, v), pix_data, exp_pix);
    check("frame_tick", {15'h0, frame_tick}, {15'h0, exp_tick});
  endtask

  task automatic write_char(int addr, int code, bit v, int x, int y);
    char_we   = 1'b1;
    char_addr = 3'(addr);
    char_code = 7'(code);
    step(v, x, y);
    char_we   = 1'b0;
  endtask

  task automatic flush();
    step(1, 5, 5);
    step(1, 6, 5);
  endtask

  int codes [4] = '{'h20, 'h7F, 'h41, 'h61};

  initial begin
    model_reset();
    sys_rst = 1'b1; mode = 2'b00; char_we = 1'b0; char_addr = 3'd0; char_code = 7'h20;
    pix_valid = 1'b0; pix_x = 10'd0; pix_y = 10'd0;

    // Reset held with random pixel inputs
    for (int i = 0; i < 3; i++) step($urandom_range(1, 0), $urandom_range(639, 0), $urandom_range(479, 0));
    sys_rst = 1'b0;

    // Sparse frame scan with an all-space buffer
    for (int y = 0; y < 480; y += 4)
      for (int x = 0; x < 640; x += 8) step(1, x, y);
    flush();

    // Solid block at index 0: corners, neighbour and left edge
    write_char(0, 'h7F, 1, 0, 1);
    step(1, 192, 224); step(1, 223, 255); step(1, 224, 224); step(1, 191, 224);
    step(1, 192, 223); step(1, 192, 256);
    flush();

    // Out-of-range writes are dropped
    write_char(6, 'h7F, 1, 0, 1);
    write_char(7, 'h7F, 1, 0, 1);
    step(1, 192 + 32 * 5, 224);
    flush();

    // Write 'A' while reading index 0 in the same cycle, then row 0 of 'A'
    write_char(0, 'h41, 1, 192, 224);
    for (int c = 0; c < 8; c++) step(1, 192 + 4 * c, 224);
    for (int r = 0; r < 8; r++) step(1, 192 + 12, 224 + 4 * r);
    flush();

    // Scroll mode with a solid block at index 0
    write_char(0, 'h7F, 1, 0, 1);
    mode = 2'b10;
    for (int f = 0; f < 3; f++) begin
      step(1, 0, 0);
      step(1, 192, 224); step(1, 221, 224); step(1, 224, 224); step(1, 430, 224);
    end
    for (int f = 0; f < 200; f++) begin
      step(1, 0, 0);
      step(1, 192 + $urandom_range(W - 1, 0), 224 + $urandom_range(H - 1, 0));
    end
    step(1, 192, 224); step(1, 200, 230);

    // Reset mid-scroll, then confirm offset cleared
    sys_rst = 1'b1;
    step(1, 200, 230);
    sys_rst = 1'b0;
    step(1, 192, 224); step(1, 192, 224); step(1, 192, 224); step(1, 380, 224);
    flush();

    // Blink with BLINK_FRAMES=2
    write_char(0, 'h7F, 1, 0, 1);
    mode = 2'b01;
    for (int f = 0; f < 6; f++) begin
      step(1, 0, 0);
      step(1, 192, 224); step(1, 200, 240);
    end
    step(1, 0, 0);
    step(1, 192, 224);
    mode = 2'b00;
    step(1, 192, 224); step(1, 192, 224); step(1, 210, 250);
    flush();

    // pix_valid low at the origin: no tick, black output
    mode = 2'b11;
    step(0, 0, 0); step(0, 192, 224); step(0, 0, 0);
    flush();

    // Randomized frames
    for (int f = 0; f < 40; f++) begin
      mode = 2'($urandom_range(3, 0));
      step(1, 0, 0);
      for (int p = 0; p < 150; p++) begin
        if ($urandom_range(9, 0) == 0)
          write_char($urandom_range(7, 0), codes[$urandom_range(3, 0)],
                     $urandom_range(4, 0) != 0, $urandom_range(420, 150), $urandom_range(270, 200));
        else
          step($urandom_range(4, 0) != 0, $urandom_range(420, 150), $urandom_range(270, 200));
      end
    end
    flush();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
